// File: rtl/nearest_hit_scanner_pkg.sv
// rt_pkg: shared ray-tracer types and constants.
//   vector      - signed 32.32 (x, y, z)
//   fixed_real  - signed 32.32 scalar
//   color       - 8-bit RGB
//   T_FAR       - "no hit" distance
//   RAD/RADSQ   - sphere radius and radius squared (480, 230400)
//   fx_mul      - 32.32 multiply
//   fx_sqrt     - 32.32 square root
//   scan_state_e - FSM states of nearest_hit_scanner
// Optional feature macro used by the scanner: NEAREST_HIT_STATS_EN.
package rt_pkg;

    typedef logic signed [63:0] fixed_real;

    typedef struct packed {
        fixed_real x;
        fixed_real y;
        fixed_real z;
    } vector;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } color;

    localparam fixed_real T_FAR = 64'sh7FFF_FFFF_FFFF_FFFF;
    localparam fixed_real RAD   = 64'sh0000_01E0_0000_0000;
    localparam fixed_real RADSQ = 64'sh0003_8400_0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } scan_state_e;

    function automatic fixed_real fx_mul(input fixed_real a, input fixed_real b);
        logic signed [127:0] p;
        p = 128'(a) * 128'(b);
        return fixed_real'(p >>> 32);
    endfunction

    // Bit-serial integer root of v * 2^32, which is the 32.32 root of v.
    // Caller guarantees v >= 0.
    function automatic logic [47:0] fx_sqrt(input fixed_real v);
        logic [95:0] x;
        logic [47:0] res;
        logic [47:0] trial;
        logic [95:0] sq;
        x   = {v, 32'h0};
        res = '0;
        for (int unsigned k = 0; k < 48; k++) begin
            trial = res | (48'd1 << (47 - k));
            sq    = 96'(trial) * 96'(trial);
            if (sq <= x) begin
                res = trial;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/nearest_hit_scanner_if.sv
// nearest_hit_scanner_if: ray request, scene ROM and result signals.
//   start, ray           - scan request from the ray generator
//   sph_addr, sph_data   - scene ROM (registered, one-cycle read latency)
//   busy, done, hit,
//   hit_t, hit_idx       - scan status and nearest-hit result
//   hit_count            - only with NEAREST_HIT_STATS_EN
// master: ray generator / ROM side. slave: the scanner.
interface nearest_hit_scanner_if
    import rt_pkg::*;
#(
    parameter int IDX_W = 3
);
    logic             start;
    vector            ray;
    logic [IDX_W-1:0] sph_addr;
    vector            sph_data;
    logic             busy;
    logic             done;
    logic             hit;
    fixed_real        hit_t;
    logic [IDX_W-1:0] hit_idx;
`ifdef NEAREST_HIT_STATS_EN
    logic [IDX_W:0]   hit_count;
`endif

    modport master (
        output start, ray, sph_data,
        input  sph_addr, busy, done, hit, hit_t, hit_idx
`ifdef NEAREST_HIT_STATS_EN
        , input hit_count
`endif
    );

    modport slave (
        input  start, ray, sph_data,
        output sph_addr, busy, done, hit, hit_t, hit_idx
`ifdef NEAREST_HIT_STATS_EN
        , output hit_count
`endif
    );

endinterface

// File: rtl/nearest_hit_scanner_collision_detection.sv
// collision_detection: combinational ray/sphere intersection (camera at origin).
//   ray       - unit ray direction, 32.32
//   center    - sphere centre, 32.32
//   tbest     - current best distance
//   Collision - ray line intersects the sphere
//   tnew      - near intersection distance (may be <= 0)
//   closer    - tnew < tbest (signed)
module collision_detection
    import rt_pkg::*;
(
    input  vector     ray,
    input  vector     center,
    input  fixed_real tbest,
    output logic      Collision,
    output fixed_real tnew,
    output logic      closer
);
    fixed_real tc;
    fixed_real cc;
    fixed_real d2;
    fixed_real disc;
    fixed_real thc;

    always_comb begin
        // tc: projection of centre on the ray; d2: squared miss distance.
        tc        = fx_mul(ray.x, center.x) + fx_mul(ray.y, center.y) + fx_mul(ray.z, center.z);
        cc        = fx_mul(center.x, center.x) + fx_mul(center.y, center.y) + fx_mul(center.z, center.z);
        d2        = cc - fx_mul(tc, tc);
        disc      = RADSQ - d2;
        Collision = ~disc[63];
        thc       = Collision ? fixed_real'({16'h0, fx_sqrt(disc)}) : '0;
        tnew      = tc - thc;
        closer    = (tnew < tbest);
    end

endmodule

// File: rtl/nearest_hit_scanner.sv
// nearest_hit_scanner: streams every scene sphere through collision_detection
// for one ray and reports the nearest positive hit with a one-cycle done.
//   Clk, Reset_n - clock, synchronous active-low reset
//   bus (slave)  - start/ray in, sph_addr/sph_data ROM port,
//                  busy/done/hit/hit_t/hit_idx results
// Macro NEAREST_HIT_STATS_EN adds bus.hit_count (positive hits per scan).
module nearest_hit_scanner
    import rt_pkg::*;
#(
    parameter int NUM_SPHERES = 8,
    parameter int IDX_W       = 3
) (
    input logic                  Clk,
    input logic                  Reset_n,
    nearest_hit_scanner_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(NUM_SPHERES - 1);

    scan_state_e      state_q, state_d;
    vector            ray_q, ray_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0] eval_idx_q, eval_idx_d;
    logic             eval_vld_q, eval_vld_d;
    fixed_real        tbest_q, tbest_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic             found_q, found_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             hit_q, hit_d;
    fixed_real        hit_t_q, hit_t_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
`ifdef NEAREST_HIT_STATS_EN
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic [IDX_W:0]   hit_count_q, hit_count_d;
`endif

    logic      collision;
    logic      closer;
    fixed_real tnew;
    logic      fwd_hit;
    logic      accept;

    collision_detection u_collision (
        .ray       (ray_q),
        .center    (bus.sph_data),
        .tbest     (tbest_q),
        .Collision (collision),
        .tnew      (tnew),
        .closer    (closer)
    );

    assign fwd_hit = collision && !tnew[63] && (tnew != '0);
    assign accept  = eval_vld_q && fwd_hit && closer;

    always_comb begin
        state_d    = state_q;
        ray_d      = ray_q;
        addr_d     = addr_q;
        eval_idx_d = addr_q;
        eval_vld_d = 1'b0;
        tbest_d    = tbest_q;
        best_idx_d = best_idx_q;
        found_d    = found_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        hit_d      = hit_q;
        hit_t_d    = hit_t_q;
        hit_idx_d  = hit_idx_q;
`ifdef NEAREST_HIT_STATS_EN
        cnt_d       = cnt_q;
        hit_count_d = hit_count_q;
        if (eval_vld_q && fwd_hit) begin
            cnt_d = cnt_q + (IDX_W+1)'(1);
        end
`endif

        // Evaluation slot trails the address by one cycle (registered ROM).
        if (accept) begin
            tbest_d    = tnew;
            best_idx_d = eval_idx_q;
            found_d    = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = SCAN;
                    ray_d      = bus.ray;
                    addr_d     = '0;
                    tbest_d    = T_FAR;
                    best_idx_d = '0;
                    found_d    = 1'b0;
                    busy_d     = 1'b1;
`ifdef NEAREST_HIT_STATS_EN
                    cnt_d      = '0;
`endif
                end
            end
            SCAN: begin
                eval_vld_d = 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + IDX_W'(1);
                end
            end
            DRAIN: begin
                // Results include this cycle's evaluation of the last sphere.
                state_d   = IDLE;
                addr_d    = '0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                hit_d     = found_d;
                hit_t_d   = tbest_d;
                hit_idx_d = best_idx_d;
`ifdef NEAREST_HIT_STATS_EN
                hit_count_d = cnt_d;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            ray_q      <= '0;
            addr_q     <= '0;
            eval_idx_q <= '0;
            eval_vld_q <= 1'b0;
            tbest_q    <= T_FAR;
            best_idx_q <= '0;
            found_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            hit_t_q    <= T_FAR;
            hit_idx_q  <= '0;
`ifdef NEAREST_HIT_STATS_EN
            cnt_q       <= '0;
            hit_count_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ray_q      <= ray_d;
            addr_q     <= addr_d;
            eval_idx_q <= eval_idx_d;
            eval_vld_q <= eval_vld_d;
            tbest_q    <= tbest_d;
            best_idx_q <= best_idx_d;
            found_q    <= found_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hit_q      <= hit_d;
            hit_t_q    <= hit_t_d;
            hit_idx_q  <= hit_idx_d;
`ifdef NEAREST_HIT_STATS_EN
            cnt_q       <= cnt_d;
            hit_count_q <= hit_count_d;
`endif
        end
    end

    assign bus.sph_addr = addr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.hit      = hit_q;
    assign bus.hit_t    = hit_t_q;
    assign bus.hit_idx  = hit_idx_q;
`ifdef NEAREST_HIT_STATS_EN
    assign bus.hit_count = hit_count_q;
`endif

endmodule

// File: doc/nearest_hit_scanner.md
# nearest_hit_scanner

Sequential scene scanner feeding the combinational sphere collision test. For one primary ray it streams every sphere centre from the scene ROM through an internal `collision_detection` instance. It keeps the running best hit distance (`tbest`) and sphere index, then reports the nearest valid hit to the shading stage with a one-cycle `done` pulse. It sits between the per-pixel ray generator (upstream) and the shader (downstream).

## Interface
- `NUM_SPHERES`, default 8: spheres in scene ROM; must be ≥1.
- `IDX_W`, default 3: index width; `$clog2(NUM_SPHERES)`, minimum 1.
- `Clk` input, 1 bit: sole clock.
- `Reset_n` input, 1 bit: synchronous, active-low reset.
- `start` input, 1 bit: begin scan for `ray`; sampled only in IDLE.
- `ray` input, `vector`: ray direction, signed 32.32 per axis; latched on accepted `start`.
- `sph_addr` output, `IDX_W` bits: scene ROM address.
- `sph_data` input, `vector`: sphere centre; valid the cycle after `sph_addr` (registered ROM).
- `busy` output, 1 bit: high from accepted `start` until `done`.
- `done` output, 1 bit: one-cycle pulse; results valid.
- `hit` output, 1 bit: at least one accepted hit.
- `hit_t` output, `fixed_real`: nearest hit distance; `T_FAR` if no hit.
- `hit_idx` output, `IDX_W` bits: index of the nearest sphere; 0 if no hit.

## Operation
- FSM states: IDLE, SCAN, DRAIN.
- **IDLE**
  - `start`=1 → SCAN.
  - Latch `ray`, set `tbest_q`=`T_FAR` (64'h7FFF_FFFF_FFFF_FFFF), `best_idx_q`=0, `found_q`=0, `sph_addr`=0.
- **SCAN**
  - `sph_addr` increments by one each cycle.
  - Each cycle from the second SCAN cycle onward, evaluate `sph_data` for the sphere addressed the previous cycle.
  - When `sph_addr`=`NUM_SPHERES-1` → DRAIN.
- **DRAIN**
  - One cycle evaluating the last sphere → IDLE.
  - Register outputs and pulse `done`.
- **Acceptance rule** (signed 32.32 compare):
  - `Collision`=1, and
  - `tnew`>0 (sign bit clear and nonzero), and
  - `tnew` < `tbest_q`.
  - On acceptance, update `tbest_q`, `best_idx_q`, `found_q`.
  - Strict `<`: on equal t the lower index wins.
- The collision instance's `tbest` input is driven from `tbest_q`.
- `ray` changes after acceptance are ignored. `start` outside IDLE is ignored.
- `hit`, `hit_t`, `hit_idx` hold their values until the next `done`.
- **Reset** (any cycle, including mid-scan) → IDLE. Output reset values:
  - `busy`=0, `done`=0, `hit`=0.
  - `hit_t`=`T_FAR`, `hit_idx`=0, `sph_addr`=0.

## Timing
- `start` sampled at edge E0 → `sph_addr`=i during cycle i (after E(i)).
- Sphere i is evaluated at edge E(i+2).
- `done`, `hit`, `hit_t`, `hit_idx` update at edge E(NUM_SPHERES+1).
- Latency from `start` edge to `done` high: NUM_SPHERES+1 cycles.
- Throughput: one sphere per cycle.
- `busy` is high for exactly NUM_SPHERES+1 cycles.
- `done` is high during the first IDLE cycle. A `start` sampled in that cycle is accepted (back-to-back rays, no bubble).
- NUM_SPHERES=1: SCAN lasts one cycle, then DRAIN; `done` at E2.

## Configuration
- Macro `NEAREST_HIT_STATS_EN`.
- Defined: extra output `hit_count` (`IDX_W+1` bits).
  - Counts spheres with `Collision`=1 and `tnew`>0, regardless of nearest.
  - Cleared on accepted `start`, updated alongside `done`, reset to 0.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package `rt_pkg` holds:
  - Typedefs `vector`, `fixed_real`, `color`.
  - Constant `T_FAR`.
  - Sphere radius constants `RAD`, `RADSQ` (480, 230400 in 32.32).
- One sub-module: the existing `collision_detection`, instantiated once, combinational between the `sph_data` and acceptance registers.
- FSM, address counter and best-hit registers stay in this module.

## Test plan
All positions in units of 2^32; `ray`=(0,0,1), NUM_SPHERES=4.
- **Single hit**
  - Sphere 2=(0,0,1000); others (5000,0,1000) (misses).
  - Expect `done` 5 cycles after `start`, `hit`=1, `hit_idx`=2, `hit_t`=520.
- **Nearest selection**
  - Spheres 0=(0,0,2000), 1=(0,0,1000), 2=(0,0,3000), 3=miss.
  - Expect `hit_idx`=1, `hit_t`=520.
- **Behind camera / tie**
  - Sphere 0=(0,0,-1000), rejected (t=-1480).
  - Spheres 1 and 3=(0,0,1000).
  - Expect `hit_idx`=1, `hit_t`=520.
  - With `NEAREST_HIT_STATS_EN`: `hit_count`=2.
- **No hit**
  - All spheres (5000,0,1000).
  - Expect `hit`=0, `hit_t`=`T_FAR`, `hit_idx`=0.
- **Handshake**
  - `start` held high during the scan → ignored.
  - `start` in the `done` cycle → second scan; its `done` exactly 5 cycles later.
  - `ray` changed mid-scan → no effect.
- **Reset mid-scan**
  - `Reset_n`=0 at cycle 2.
  - Expect `busy`=0, `done` never pulses, outputs at reset values.
  - A subsequent `start` completes normally.
